// File: rtl/bmp_row_compare_acc.sv
// -----------------------------------------------------------------------------
// bmp_row_compare_acc
//
// Walks all rows of the 24x64 bitmap register, fetching each row together with
// the matching template row. For every row it counts the bit positions where
// the two agree, and it sums those counts over the whole bitmap. At the end it
// reports a similarity score, a one-cycle done pulse and a threshold match flag.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      begin a comparison (accepted only when idle)
//   abort      synchronous abort of a running comparison
//   threshold  match threshold, captured when start is accepted
//   row_addr   row address to bitmap register and template store
//   rd_en      read enable to bitmap register and template store
//   bmp_row    bitmap row, valid one cycle after rd_en
//   tmpl_row   template row, valid one cycle after rd_en
//   busy       comparison in progress
//   done       one-cycle pulse, score and match valid
//   score      total agreeing bits of the last completed comparison
//   match      score >= captured threshold, last completed comparison
// -----------------------------------------------------------------------------
module bmp_row_compare_acc #(
    parameter int ROWS    = 64,
    parameter int COLS    = 24,
    parameter int ADDR_W  = 6,
    parameter int SCORE_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SCORE_W-1:0] threshold,
    output logic [ADDR_W-1:0]  row_addr,
    output logic               rd_en,
    input  logic [COLS-1:0]    bmp_row,
    input  logic [COLS-1:0]    tmpl_row,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic               match
);

    localparam int CNT_W = $clog2(COLS + 1);
    localparam logic [ADDR_W-1:0]  LAST_ROW   = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1'b1);
    localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of bit positions in which the two rows agree.
    function automatic logic [CNT_W-1:0] agree_count(
        input logic [COLS-1:0] a,
        input logic [COLS-1:0] b
    );
        logic [COLS-1:0]  same;
        logic [CNT_W-1:0] cnt;
        same = ~(a ^ b);
        cnt  = {CNT_W{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            cnt = cnt + CNT_W'(same[i]);
        end
        return cnt;
    endfunction

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  row_addr_r, row_addr_s;
    logic               rd_en_r, rd_en_s;
    logic               vld_r, vld_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [SCORE_W-1:0] acc_r, acc_s;
    logic [SCORE_W-1:0] thr_r, thr_s;
    logic [SCORE_W-1:0] score_r, score_s;
    logic               match_r, match_s;
    logic [SCORE_W-1:0] row_sum_s;
    logic [SCORE_W-1:0] acc_plus_s;

    // Running total including the row currently on the data inputs, if valid.
    always_comb begin
        row_sum_s = SCORE_W'(agree_count(bmp_row, tmpl_row));
        if (vld_r) begin
            acc_plus_s = acc_r + row_sum_s;
        end else begin
            acc_plus_s = acc_r;
        end
    end

    // Next-state and next-output logic of the row sequencer.
    always_comb begin
        state_s    = state_r;
        row_addr_s = row_addr_r;
        rd_en_s    = rd_en_r;
        vld_s      = rd_en_r;       // data arrives one cycle after the read
        busy_s     = busy_r;
        done_s     = 1'b0;
        acc_s      = acc_plus_s;
        thr_s      = thr_r;
        score_s    = score_r;
        match_s    = match_r;

        case (state_r)
            ST_IDLE: begin
                rd_en_s = 1'b0;
                busy_s  = 1'b0;
                if (start) begin
                    state_s    = ST_RUN;
                    thr_s      = threshold;
                    acc_s      = SCORE_ZERO;
                    row_addr_s = ADDR_ZERO;
                    rd_en_s    = 1'b1;
                    busy_s     = 1'b1;
                    vld_s      = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Drop the pipeline too, so no stale row lands in the cleared sum.
                    state_s = ST_IDLE;
                    rd_en_s = 1'b0;
                    busy_s  = 1'b0;
                    vld_s   = 1'b0;
                    acc_s   = SCORE_ZERO;
                end else if (row_addr_r == LAST_ROW) begin
                    // Address holds on the last row instead of wrapping.
                    state_s = ST_DRAIN;
                    rd_en_s = 1'b0;
                end else begin
                    row_addr_s = row_addr_r + ADDR_ONE;
                    rd_en_s    = 1'b1;
                end
            end
            ST_DRAIN: begin
                rd_en_s = 1'b0;
                if (abort) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    vld_s   = 1'b0;
                    acc_s   = SCORE_ZERO;
                end else begin
                    // Last row is folded in on the same edge that publishes the result.
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    score_s = acc_plus_s;
                    match_s = (acc_plus_s >= thr_r);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                rd_en_s = 1'b0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                rd_en_s = 1'b0;
                busy_s  = 1'b0;
                vld_s   = 1'b0;
                acc_s   = SCORE_ZERO;
            end
        endcase
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            row_addr_r <= ADDR_ZERO;
            rd_en_r    <= 1'b0;
            vld_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            acc_r      <= SCORE_ZERO;
            thr_r      <= SCORE_ZERO;
            score_r    <= SCORE_ZERO;
            match_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            row_addr_r <= row_addr_s;
            rd_en_r    <= rd_en_s;
            vld_r      <= vld_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            acc_r      <= acc_s;
            thr_r      <= thr_s;
            score_r    <= score_s;
            match_r    <= match_s;
        end
    end

    assign row_addr = row_addr_r;
    assign rd_en    = rd_en_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign score    = score_r;
    assign match    = match_r;

endmodule
